// File: rtl/multicycle_control_if.sv
// Bundle of memory handshakes and datapath control lines around the multi-cycle RV32I controller.
// The controller takes the master side; memories and datapath take the slave side.
interface multicycle_control_if;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic        dmem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [1:0]  dmem_size;
  logic        dmem_unsigned;
  logic        branch_taken;
  logic        wr_en;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] imm_data;
  logic [3:0]  alu_op;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  reg_sel;
  logic [1:0]  pc_next_sel;
  logic        trap;

  modport master (
    input  imem_rdata, imem_ack, dmem_ack, branch_taken,
    output imem_req, dmem_req, dmem_we, dmem_size, dmem_unsigned,
           wr_en, rd_idx, rs1_idx, rs2_idx, imm_data, alu_op,
           alu_a_sel, alu_b_sel, reg_sel, pc_next_sel, trap
  );

  modport slave (
    output imem_rdata, imem_ack, dmem_ack, branch_taken,
    input  imem_req, dmem_req, dmem_we, dmem_size, dmem_unsigned,
           wr_en, rd_idx, rs1_idx, rs2_idx, imm_data, alu_op,
           alu_a_sel, alu_b_sel, reg_sel, pc_next_sel, trap
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetches into an internal IR, decodes it, and sequences
// EXEC/MEM/WB while driving datapath selects and the req/ack memory handshakes.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int HAS_FENCE   = 1
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1, ALU_LT  = 4'd2, ALU_LTU = 4'd3,
                         ALU_XOR = 4'd4,  ALU_OR  = 4'd5, ALU_AND = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8,  ALU_SRA = 4'd9, ALU_EQ  = 4'd10;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL  = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                         OPC_MISC = 7'b0001111;

  localparam logic [1:0] REG_ALU = 2'd0, REG_MEM = 2'd1, REG_PC4 = 2'd2;
  localparam logic [1:0] PC_SAME = 2'd0, PC_INC = 2'd1, PC_ALU = 2'd2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t state, state_next;
  logic [31:0] ir;
  logic [CNT_W-1:0] wait_cnt;
  logic take_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic legal, writes_rd, is_mem, is_store, is_branch, is_jump, rs1_zero;
  logic dec_a, dec_b;
  logic [3:0] dec_alu;
  logic [1:0] dec_reg;
  logic [31:0] dec_imm;
  logic waiting, timed_out, active;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign waiting   = ((state == S_FETCH) && !bus.imem_ack) || ((state == S_MEM) && !bus.dmem_ack);
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign active    = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_LT;
      3'b011:  alu_of = ALU_LTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_RST;
    else         state <= state_next;
  end

  // IR capture, per-request wait counter and the branch decision taken in EXEC
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ir       <= NOP;
      wait_cnt <= '0;
      take_q   <= 1'b0;
    end else begin
      if ((state == S_FETCH) && bus.imem_ack) ir <= bus.imem_rdata;
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (state == S_EXEC) take_q <= bus.branch_taken ^ funct3[0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:    state_next = S_FETCH;
      S_FETCH:  if (bus.imem_ack) state_next = S_DECODE;
                else if (timed_out) state_next = S_TRAP;
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_next = is_mem ? S_MEM : S_WB;
      S_MEM:    if (bus.dmem_ack) state_next = S_WB;
                else if (timed_out) state_next = S_TRAP;
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_RST;
    endcase
  end

  // Instruction decode from the latched IR only
  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    rs1_zero  = 1'b0;
    dec_a     = 1'b0;
    dec_b     = 1'b0;
    dec_alu   = ALU_ADD;
    dec_reg   = REG_ALU;
    dec_imm   = 32'd0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1; dec_b = 1'b1; dec_imm = imm_u; rs1_zero = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1; dec_a = 1'b1; dec_b = 1'b1; dec_imm = imm_u;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; is_jump = 1'b1; dec_a = 1'b1; dec_b = 1'b1;
        dec_imm = imm_j; dec_reg = REG_PC4;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'b000); writes_rd = 1'b1; is_jump = 1'b1; dec_b = 1'b1;
        dec_imm = imm_i; dec_reg = REG_PC4;
      end
      OPC_BRANCH: begin
        legal = (funct3[2:1] != 2'b01); is_branch = 1'b1; dec_imm = imm_b;
        dec_alu = funct3[2] ? (funct3[1] ? ALU_LTU : ALU_LT) : ALU_EQ;
      end
      OPC_LOAD: begin
        legal = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
        writes_rd = 1'b1; is_mem = 1'b1; dec_b = 1'b1; dec_imm = imm_i; dec_reg = REG_MEM;
      end
      OPC_STORE: begin
        legal = !funct3[2] && (funct3[1:0] != 2'b11);
        is_mem = 1'b1; is_store = 1'b1; dec_b = 1'b1; dec_imm = imm_s;
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == 7'h00);
          3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
        writes_rd = 1'b1; dec_b = 1'b1; dec_imm = imm_i;
        dec_alu = alu_of(funct3, (funct3 == 3'b101) && ir[30]);
      end
      OPC_OP: begin
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        writes_rd = 1'b1; dec_alu = alu_of(funct3, ir[30]);
      end
      OPC_MISC: legal = (HAS_FENCE != 0) && (funct3[2:1] == 2'b00);
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    bus.imem_req      = 1'b0;
    bus.dmem_req      = 1'b0;
    bus.dmem_we       = 1'b0;
    bus.dmem_size     = 2'd0;
    bus.dmem_unsigned = 1'b0;
    bus.wr_en         = 1'b0;
    bus.rd_idx        = 5'd0;
    bus.rs1_idx       = 5'd0;
    bus.rs2_idx       = 5'd0;
    bus.imm_data      = 32'd0;
    bus.alu_op        = ALU_ADD;
    bus.alu_a_sel     = 1'b0;
    bus.alu_b_sel     = 1'b0;
    bus.reg_sel       = REG_ALU;
    bus.pc_next_sel   = PC_SAME;
    bus.trap          = (state == S_TRAP);
    if (active) begin
      bus.rd_idx    = ir[11:7];
      bus.rs1_idx   = rs1_zero ? 5'd0 : ir[19:15];
      bus.rs2_idx   = ir[24:20];
      bus.imm_data  = dec_imm;
      bus.alu_op    = dec_alu;
      bus.alu_a_sel = dec_a;
      bus.alu_b_sel = dec_b;
      bus.reg_sel   = dec_reg;
    end
    if (state == S_FETCH) bus.imem_req = 1'b1;
    if (state == S_MEM) begin
      bus.dmem_req      = 1'b1;
      bus.dmem_we       = is_store;
      bus.dmem_size     = funct3[1:0];
      bus.dmem_unsigned = !is_store && funct3[2];
    end
    // In WB a branch reuses the ALU for the PC+imm target
    if (state == S_WB) begin
      bus.wr_en       = writes_rd && (ir[11:7] != 5'd0);
      bus.pc_next_sel = (is_jump || (is_branch && take_q)) ? PC_ALU : PC_INC;
      if (is_branch) begin
        bus.alu_op    = ALU_ADD;
        bus.alu_a_sel = 1'b1;
        bus.alu_b_sel = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks hand-encoded RV32I instructions through the FSM
// and checks handshakes, decoded fields, trap behaviour and asynchronous reset.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  multicycle_control_if bus();

  multicycle_control #(.MEM_TIMEOUT(16), .HAS_FENCE(1)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the FSM in its first FETCH cycle after a reset pulse
  task automatic start_up();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_output("rst_state_req_low", 32'(bus.imem_req), 32'd0);
    tick();
    check_output("fetch_after_rst", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic apply_fetch(input logic [31:0] instr, input int waits);
    for (int i = 0; i < waits; i++) begin
      bus.imem_rdata = 32'hDEAD_BEEF;
      check_output("fetch_req_wait", 32'(bus.imem_req), 32'd1);
      tick();
    end
    bus.imem_rdata = instr;
    bus.imem_ack   = 1'b1;
    check_output("fetch_req_ack", 32'(bus.imem_req), 32'd1);
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hFFFF_FFFF;
  endtask

  task automatic apply_mem(input int waits);
    for (int i = 0; i < waits; i++) begin
      check_output("mem_req_wait", 32'(bus.dmem_req), 32'd1);
      tick();
    end
    bus.dmem_ack = 1'b1;
    check_output("mem_req_ack", 32'(bus.dmem_req), 32'd1);
    tick();
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    bus.imem_rdata   = 32'h0;
    bus.imem_ack     = 1'b1;
    bus.dmem_ack     = 1'b1;
    bus.branch_taken = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    check_output("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check_output("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check_output("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_output("rst_trap", 32'(bus.trap), 32'd0);
    check_output("rst_imm", bus.imm_data, 32'd0);
    check_output("rst_pc_next", 32'(bus.pc_next_sel), 32'd0);
    check_output("rst_alu_b", 32'(bus.alu_b_sel), 32'd0);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    start_up();

    // ADDI x1,x0,5
    apply_fetch(32'h0050_0093, 0);
    check_output("addi_dec_req", 32'(bus.imem_req), 32'd0);
    check_output("addi_rd", 32'(bus.rd_idx), 32'd1);
    check_output("addi_imm", bus.imm_data, 32'd5);
    check_output("addi_dec_wr", 32'(bus.wr_en), 32'd0);
    tick();
    check_output("addi_alu_b", 32'(bus.alu_b_sel), 32'd1);
    check_output("addi_alu_op", 32'(bus.alu_op), 32'd0);
    tick();
    check_output("addi_wb_wr", 32'(bus.wr_en), 32'd1);
    check_output("addi_wb_pc", 32'(bus.pc_next_sel), 32'd1);
    check_output("addi_wb_regsel", 32'(bus.reg_sel), 32'd0);
    tick();
    check_output("addi_next_fetch", 32'(bus.imem_req), 32'd1);
    check_output("addi_fetch_wr", 32'(bus.wr_en), 32'd0);
    check_output("addi_fetch_pc", 32'(bus.pc_next_sel), 32'd0);

    // LW x2,8(x1) with fetch wait and a 3-cycle data access
    apply_fetch(32'h0080_A103, 2);
    check_output("lw_rd", 32'(bus.rd_idx), 32'd2);
    check_output("lw_rs1", 32'(bus.rs1_idx), 32'd1);
    check_output("lw_imm", bus.imm_data, 32'd8);
    tick();
    check_output("lw_exec_dreq", 32'(bus.dmem_req), 32'd0);
    tick();
    check_output("lw_we", 32'(bus.dmem_we), 32'd0);
    check_output("lw_size", 32'(bus.dmem_size), 32'd2);
    check_output("lw_unsigned", 32'(bus.dmem_unsigned), 32'd0);
    apply_mem(2);
    check_output("lw_wb_dreq", 32'(bus.dmem_req), 32'd0);
    check_output("lw_wb_wr", 32'(bus.wr_en), 32'd1);
    check_output("lw_wb_regsel", 32'(bus.reg_sel), 32'd1);
    check_output("lw_wb_pc", 32'(bus.pc_next_sel), 32'd1);
    tick();

    // Data ack while nothing is outstanding on dmem
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    check_output("stray_ack_fetch", 32'(bus.imem_req), 32'd1);
    check_output("stray_ack_dreq", 32'(bus.dmem_req), 32'd0);

    // SW x2,4(x1)
    apply_fetch(32'h0020_A223, 0);
    check_output("sw_imm", bus.imm_data, 32'd4);
    check_output("sw_rs2", 32'(bus.rs2_idx), 32'd2);
    tick();
    tick();
    check_output("sw_we", 32'(bus.dmem_we), 32'd1);
    check_output("sw_size", 32'(bus.dmem_size), 32'd2);
    apply_mem(0);
    check_output("sw_wb_wr", 32'(bus.wr_en), 32'd0);
    check_output("sw_wb_pc", 32'(bus.pc_next_sel), 32'd1);
    tick();

    // BEQ taken, imm -8
    bus.branch_taken = 1'b1;
    apply_fetch(32'hFE00_0CE3, 0);
    check_output("beq_imm", bus.imm_data, 32'hFFFF_FFF8);
    tick();
    check_output("beq_alu_op", 32'(bus.alu_op), 32'd10);
    tick();
    check_output("beq_wb_pc", 32'(bus.pc_next_sel), 32'd2);
    check_output("beq_wb_wr", 32'(bus.wr_en), 32'd0);
    tick();

    // BNE with the same compare result falls through
    apply_fetch(32'hFE00_1CE3, 0);
    tick();
    tick();
    check_output("bne_wb_pc", 32'(bus.pc_next_sel), 32'd1);
    tick();
    bus.branch_taken = 1'b0;

    // JAL x1,+16
    apply_fetch(32'h0100_00EF, 0);
    check_output("jal_imm", bus.imm_data, 32'd16);
    check_output("jal_rd", 32'(bus.rd_idx), 32'd1);
    tick();
    tick();
    check_output("jal_wb_regsel", 32'(bus.reg_sel), 32'd2);
    check_output("jal_wb_pc", 32'(bus.pc_next_sel), 32'd2);
    check_output("jal_wb_wr", 32'(bus.wr_en), 32'd1);
    tick();

    // ADDI x0,x0,1 must not strobe a write
    apply_fetch(32'h0010_0013, 0);
    tick();
    tick();
    check_output("addi_x0_wr", 32'(bus.wr_en), 32'd0);
    check_output("addi_x0_pc", 32'(bus.pc_next_sel), 32'd1);
    tick();

    // SRAI x1,x1,1 is legal with funct7 0x20
    apply_fetch(32'h4010_D093, 0);
    tick();
    check_output("srai_alu_op", 32'(bus.alu_op), 32'd9);
    tick();
    check_output("srai_wb_wr", 32'(bus.wr_en), 32'd1);
    tick();

    // Illegal opcode 0x7F traps after DECODE and stays there
    apply_fetch(32'h0000_007F, 0);
    check_output("ill_dec_trap", 32'(bus.trap), 32'd0);
    tick();
    check_output("ill_trap", 32'(bus.trap), 32'd1);
    check_output("ill_trap_ireq", 32'(bus.imem_req), 32'd0);
    bus.imem_ack = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    check_output("ill_trap_sticky", 32'(bus.trap), 32'd1);
    check_output("ill_trap_ireq2", 32'(bus.imem_req), 32'd0);
    check_output("ill_trap_wr", 32'(bus.wr_en), 32'd0);
    check_output("ill_trap_pc", 32'(bus.pc_next_sel), 32'd0);

    // SLLI with funct7 0x20 is illegal
    start_up();
    check_output("reset_clears_trap", 32'(bus.trap), 32'd0);
    apply_fetch(32'h4000_9093, 0);
    tick();
    check_output("bad_slli_trap", 32'(bus.trap), 32'd1);

    // Fetch never acknowledged: request held 16 cycles, then trap
    start_up();
    for (int i = 0; i < 16; i++) begin
      check_output("timeout_req_held", 32'(bus.imem_req), 32'd1);
      check_output("timeout_no_trap_yet", 32'(bus.trap), 32'd0);
      tick();
    end
    check_output("timeout_trap", 32'(bus.trap), 32'd1);
    check_output("timeout_req_drop", 32'(bus.imem_req), 32'd0);

    // Asynchronous reset while a load is in MEM
    start_up();
    apply_fetch(32'h0080_A103, 0);
    tick();
    tick();
    check_output("mid_mem_dreq", 32'(bus.dmem_req), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_output("async_rst_dreq", 32'(bus.dmem_req), 32'd0);
    check_output("async_rst_wr", 32'(bus.wr_en), 32'd0);
    tick();
    rstn = 1'b1;
    check_output("post_rst_rst_state", 32'(bus.imem_req), 32'd0);
    tick();
    check_output("post_rst_fetch", 32'(bus.imem_req), 32'd1);
    apply_fetch(32'h0050_0093, 0);
    check_output("post_rst_addi_rd", 32'(bus.rd_idx), 32'd1);
    check_output("post_rst_addi_imm", bus.imm_data, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
